regfile_param: RTL and testbench

Parametrised successor to the team's fixed 32x32 two-read register file. It has configurable data width, depth and number of read ports. Same-cycle write-to-read bypass is optional. A sequential bulk-clear engine zeroes the array one entry per cycle without asserting reset. It sits in the processor decode/writeback stage and serves as the common register-array primitive for future multi-issue and coprocessor register files.

---
 rtl/regfile_param.sv | 98 +++++++++
 tb/tb_regfile_param.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised register array: NUM_READ combinational read ports, one write port,
// optional same-cycle write bypass and a one-entry-per-cycle bulk-clear engine.
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                           clock,
  input  logic                           ctrl_reset,
  input  logic                           ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]          data_writeReg,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
  input  logic                           ctrl_clear,
  output logic                           clear_busy,
  output logic                           clear_done,
  output logic                           write_stall
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   clear_idx, clear_idx_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    write_accept;

  assign clear_busy   = (state == CLEAR);
  assign write_stall  = ctrl_writeEnable & clear_busy;
  // Writes are open in IDLE and DONE; entry 0 is read-only when hardwired.
  assign write_accept = ctrl_writeEnable && !clear_busy &&
                        !(ZERO_REG && (ctrl_writeReg == '0));

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (ctrl_reset) begin
      state     <= IDLE;
      clear_idx <= '0;
    end else begin
      state     <= state_next;
      clear_idx <= clear_idx_next;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_next     = state;
    clear_idx_next = clear_idx;
    clear_done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (ctrl_clear) begin
          state_next     = CLEAR;
          clear_idx_next = '0;
        end
      end
      CLEAR: begin
        clear_idx_next = clear_idx + ADDR_WIDTH'(1);
        if (clear_idx == '1) state_next = DONE;
      end
      DONE: begin
        clear_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      // NOTE: the array itself is reset because a zeroed register file after
      // reset is part of the block's contract; this keeps it in flops.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear_busy) begin
      mem[clear_idx] <= '0;
    end else if (write_accept) begin
      mem[ctrl_writeReg] <= data_writeReg;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDR_WIDTH-1:0] addr;
    assign addr = ctrl_readReg[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_readReg[k*DATA_WIDTH +: DATA_WIDTH] =
        (ZERO_REG && (addr == '0))                           ? '0 :
        (BYPASS && write_accept && (ctrl_writeReg == addr))  ? data_writeReg :
                                                               mem[addr];
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: three regfile_param configurations driven from shared stimulus
// and compared every cycle against an array-based model of the register file rules.
module tb_regfile_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        ctrl_reset, we, clr;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [11:0] s_raddr;
  logic [63:0] rdata_a, rdata_b, s_rdata;
  logic        busy_a, busy_b, busy_s, done_a, done_b, done_s, stall_a, stall_b, stall_s;

  regfile_param u_dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(we),
    .ctrl_writeReg(waddr), .data_writeReg(wdata), .ctrl_readReg(raddr),
    .data_readReg(rdata_a), .ctrl_clear(clr), .clear_busy(busy_a),
    .clear_done(done_a), .write_stall(stall_a)
  );

  regfile_param #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_alt (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(we),
    .ctrl_writeReg(waddr), .data_writeReg(wdata), .ctrl_readReg(raddr),
    .data_readReg(rdata_b), .ctrl_clear(clr), .clear_busy(busy_b),
    .clear_done(done_b), .write_stall(stall_b)
  );

  regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(4)) u_small (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(we),
    .ctrl_writeReg(waddr[2:0]), .data_writeReg(wdata[15:0]), .ctrl_readReg(s_raddr),
    .data_readReg(s_rdata), .ctrl_clear(clr), .clear_busy(busy_s),
    .clear_done(done_s), .write_stall(stall_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: contents per instance plus the entry the clear is on
  // (-1 = not clearing, dep = the completion cycle).
  logic [31:0] mdl [3][32];
  int pos [3] = '{-1, -1, -1};
  int dep [3] = '{32, 32, 8};
  bit zr  [3] = '{1'b1, 1'b0, 1'b1};
  bit bp  [3] = '{1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wa(int i);
    return (i == 2) ? int'(waddr[2:0]) : int'(waddr);
  endfunction

  function automatic logic [31:0] wd(int i);
    return (i == 2) ? {16'h0, wdata[15:0]} : wdata;
  endfunction

  function automatic bit clearing(int i);
    return pos[i] >= 0 && pos[i] < dep[i];
  endfunction

  function automatic bit accept(int i);
    return (we === 1'b1) && !clearing(i) && !(zr[i] && wa(i) == 0);
  endfunction

  function automatic logic [31:0] exp_rd(int i, int a);
    if (zr[i] && a == 0) return 32'h0;
    if (bp[i] && accept(i) && wa(i) == a) return wd(i);
    return mdl[i][a];
  endfunction

  task automatic check_all();
    logic [2:0]  bv, dv, sv;
    logic [31:0] e;
    int a;
    bv = {busy_s, busy_b, busy_a};
    dv = {done_s, done_b, done_a};
    sv = {stall_s, stall_b, stall_a};
    for (int i = 0; i < 3; i++) begin
      check($sformatf("busy%0d", i),  64'(bv[i]), 64'(clearing(i)));
      check($sformatf("done%0d", i),  64'(dv[i]), 64'(pos[i] == dep[i]));
      check($sformatf("stall%0d", i), 64'(sv[i]), 64'((we === 1'b1) && clearing(i)));
    end
    for (int k = 0; k < 2; k++) begin
      a = int'(raddr[k*5 +: 5]);
      check($sformatf("rd_a_p%0d_r%0d", k, a), 64'(rdata_a[k*32 +: 32]), 64'(exp_rd(0, a)));
      check($sformatf("rd_b_p%0d_r%0d", k, a), 64'(rdata_b[k*32 +: 32]), 64'(exp_rd(1, a)));
    end
    for (int k = 0; k < 4; k++) begin
      a = int'(s_raddr[k*3 +: 3]);
      e = exp_rd(2, a);
      check($sformatf("rd_s_p%0d_r%0d", k, a), 64'(s_rdata[k*16 +: 16]), 64'(e[15:0]));
    end
  endtask

  task automatic update_model();
    bit acc;
    for (int i = 0; i < 3; i++) begin
      if (ctrl_reset) begin
        for (int a = 0; a < 32; a++) mdl[i][a] = 32'h0;
        pos[i] = -1;
      end else begin
        acc = accept(i);
        if (clearing(i)) begin
          mdl[i][pos[i]] = 32'h0;
          pos[i]++;
        end else begin
          if (acc) mdl[i][wa(i)] = wd(i);
          if (pos[i] == dep[i]) pos[i] = -1;
          else if (clr) pos[i] = 0;
        end
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are compared just after it.
  task automatic step(input bit chk = 1'b1);
    #1;
    if (chk) check_all();
    @(posedge clock);
    update_model();
    @(negedge clock);
  endtask

  initial begin
    int busy_cnt, sbusy_cnt, done_cnt, sdone_cnt, done_at;

    ctrl_reset = 1'b1; we = 1'b0; clr = 1'b0;
    waddr = '0; wdata = '0; raddr = '0; s_raddr = '0;
    @(negedge clock);
    step(1'b0);
    step(1'b0);
    ctrl_reset = 1'b0;
    #1;
    check("reset_busy", 64'(busy_a), 64'(0));
    check("reset_done", 64'(done_a), 64'(0));
    step();

    // Basic write then read on both ports.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    step();
    we = 1'b0; raddr = {5'd5, 5'd5};
    #1;
    check("t1_r5_p0", 64'(rdata_a[31:0]),  64'h0000_0000_DEAD_BEEF);
    check("t1_r5_p1", 64'(rdata_a[63:32]), 64'h0000_0000_DEAD_BEEF);
    step();
    raddr = {5'd5, 5'd6};
    #1;
    check("t1_r6", 64'(rdata_a[31:0]), 64'h0);
    step();

    // Same-cycle bypass versus stored value.
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; raddr = {5'd0, 5'd7};
    #1;
    check("t2_bypass",   64'(rdata_a[31:0]), 64'h1234_5678);
    check("t2_nobypass", 64'(rdata_b[31:0]), 64'h0);
    step();
    we = 1'b0;
    #1;
    check("t2_nobypass_next", 64'(rdata_b[31:0]), 64'h1234_5678);
    step();

    // Writes to entry 0.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr = {5'd0, 5'd0};
    #1;
    check("t3_zero_same",  64'(rdata_a[31:0]), 64'h0);
    check("t3_zero_stall", 64'(stall_a), 64'h0);
    step();
    we = 1'b0;
    #1;
    check("t3_zero_next", 64'(rdata_a[31:0]), 64'h0);
    check("t3_r0_plain",  64'(rdata_b[31:0]), 64'hFFFF_FFFF);
    step();

    // Fill with index values, then run a full clear.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i);
      step();
    end
    we = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    busy_cnt = 0; sbusy_cnt = 0; done_cnt = 0; sdone_cnt = 0; done_at = -1;
    for (int c = 0; c < 40; c++) begin
      we = (c == 15); waddr = 5'd9; wdata = 32'hAAAA_5555; raddr = {5'd3, 5'd20};
      #1;
      if (busy_a) busy_cnt++;
      if (busy_s) sbusy_cnt++;
      if (done_a) begin done_cnt++; done_at = c; end
      if (done_s) sdone_cnt++;
      if (c == 10) begin
        check("t4_r20_mid", 64'(rdata_a[31:0]),  64'd20);
        check("t4_r3_mid",  64'(rdata_a[63:32]), 64'd0);
      end
      if (c == 15) check("t4_stall", 64'(stall_a), 64'd1);
      step();
    end
    we = 1'b0;
    check("t4_busy_cycles",  64'(busy_cnt),  64'd32);
    check("t4_done_pulses",  64'(done_cnt),  64'd1);
    check("t4_done_cycle",   64'(done_at),   64'd32);
    check("t6_small_busy",   64'(sbusy_cnt), 64'd8);
    check("t6_small_done",   64'(sdone_cnt), 64'd1);
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      #1;
      check($sformatf("t4_clr_a_r%0d", a), 64'(rdata_a[31:0]), 64'h0);
      check($sformatf("t4_clr_b_r%0d", a), 64'(rdata_b[31:0]), 64'h0);
      step();
    end

    // Reset in the middle of a clear.
    for (int i = 10; i < 16; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'h100 + 32'(i);
      step();
    end
    we = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    for (int c = 0; c < 5; c++) step();
    ctrl_reset = 1'b1;
    step();
    ctrl_reset = 1'b0; raddr = {5'd12, 5'd15};
    #1;
    check("t5_busy_after_reset", 64'(busy_a), 64'd0);
    check("t5_r15_after_reset",  64'(rdata_a[31:0]),  64'h0);
    check("t5_r12_after_reset",  64'(rdata_a[63:32]), 64'h0);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (done_a || done_b) done_cnt++;
      step();
    end
    check("t5_no_done", 64'(done_cnt), 64'd0);

    // Four-port narrow configuration.
    for (int i = 1; i < 8; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'hA000 + 32'h111 * 32'(i);
      step();
    end
    we = 1'b0; s_raddr = {3'd1, 3'd5, 3'd2, 3'd7};
    #1;
    check("t6_p0_r7", 64'(s_rdata[15:0]),  64'hA777);
    check("t6_p1_r2", 64'(s_rdata[31:16]), 64'hA222);
    check("t6_p2_r5", 64'(s_rdata[47:32]), 64'hA555);
    check("t6_p3_r1", 64'(s_rdata[63:48]), 64'hA111);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    sbusy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (busy_s) sbusy_cnt++;
      step();
    end
    check("t6_small_clear_len", 64'(sbusy_cnt), 64'd8);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      ctrl_reset = ($urandom_range(0, 499) == 0);
      clr        = ($urandom_range(0, 47) == 0);
      we         = 1'($urandom_range(0, 1));
      waddr      = 5'($urandom);
      wdata      = $urandom;
      raddr      = 10'($urandom);
      s_raddr    = 12'($urandom);
      if ($urandom_range(0, 3) == 0) raddr[4:0] = waddr;
      if ($urandom_range(0, 3) == 0) s_raddr[5:3] = waddr[2:0];
      step();
    end

    ctrl_reset = 1'b0; clr = 1'b0; we = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
